// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion sequencer and the serial receiver:
// frame geometry, result width and the sequencer state encoding.
package adc_pkg;

  localparam int ADC_BITS      = 16;
  localparam int DATA_W        = 12;
  localparam int RX_FRAME_BITS = ADC_BITS;  // receiver shifts one full CS-low frame
  localparam int ACC_W         = DATA_W + 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    SHIFT     = 3'd2,
    TAIL      = 3'd3,
    WAIT_DONE = 3'd4,
    CAPTURE   = 3'd5
  } state_e;

  function automatic logic cs_active(input state_e s);
    return (s == SETUP) || (s == SHIFT);
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Half-period divider for ADCclk. Emits one-cycle fall/rise strobes in the cycle
// before the corresponding edge; load_hi parks the clock high with the divider cleared.
module adc_sclk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk_Nexys,
  input  logic reset,
  input  logic en,
  input  logic load_hi,
  output logic sclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          half;

  assign half     = en && !load_hi && (div_q == CW'(CLK_DIV - 1));
  assign fall_stb = half && sclk_q;
  assign rise_stb = half && !sclk_q;
  assign sclk     = sclk_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (load_hi) begin
      div_d  = '0;
      sclk_d = 1'b1;
    end else if (half) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else if (en) begin
      div_d = div_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_Nexys or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer upstream of the serial ADC receiver: periodic CS/SCLK framing,
// result capture into a valid/ack register. Define ADC_AVG4_EN to present 4-sample averages.
module adc_conv_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 2000,
  parameter int QUIET_CYC     = 10,
  parameter int DONE_TIMEOUT  = 64
) (
  input  logic              clk_Nexys,
  input  logic              reset,
  input  logic              start_en,
  input  logic              rx_done_tick,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sample_ack,
  output logic              ADCclk,
  output logic              ADCcs_n,
  output logic              rx_en,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              overrun,
  output logic              err_timeout,
  output logic              busy
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = 16;

  state_e            state_q, state_d;
  logic [PW-1:0]     period_q, period_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [4:0]        edge_cnt_q, edge_cnt_d;
  logic              done_seen_q, done_seen_d;
  logic              cs_n_q, cs_n_d;
  logic              rx_en_q, rx_en_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              overrun_q, overrun_d;
  logic              err_timeout_q, err_timeout_d;
  logic              tick;
  logic              fall_stb, rise_stb;

`ifdef ADC_AVG4_EN
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [1:0]       avg_cnt_q, avg_cnt_d;

  assign acc_sum = acc_q + {2'b00, data_in};
`endif

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk_Nexys (clk_Nexys),
    .reset     (reset),
    .en        (state_q == SHIFT),
    .load_hi   (state_q != SHIFT),
    .sclk      (ADCclk),
    .fall_stb  (fall_stb),
    .rise_stb  (rise_stb)
  );

  // Ticks keep coming while busy; IDLE is the only state that listens.
  assign tick = start_en && (period_q == PW'(SAMPLE_PERIOD - 1));

  always_comb begin
    period_d = '0;
    if (start_en && !tick) period_d = period_q + 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = (state_q == IDLE) ? '0 : timer_q + 1'b1;
    edge_cnt_d     = '0;
    done_seen_d    = done_seen_q;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    err_timeout_d  = err_timeout_q;
`ifdef ADC_AVG4_EN
    acc_d          = acc_q;
    avg_cnt_d      = avg_cnt_q;
`endif

    if (sample_valid_q && sample_ack) sample_valid_d = 1'b0;
    if (rx_done_tick && (cs_active(state_q) || state_q == TAIL)) done_seen_d = 1'b1;

    case (state_q)
      IDLE:  if (tick) state_d = SETUP;
      SETUP: if (timer_q == TW'(CLK_DIV - 1)) state_d = SHIFT;
      SHIFT: begin
        edge_cnt_d = edge_cnt_q + {4'b0000, fall_stb};
        if (rise_stb && edge_cnt_q == 5'(ADC_BITS)) state_d = TAIL;
      end
      TAIL: begin
        if (timer_q == TW'(QUIET_CYC - 1))
          state_d = (done_seen_q || rx_done_tick) ? CAPTURE : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (rx_done_tick) begin
          state_d = CAPTURE;
        end else if (timer_q == TW'(DONE_TIMEOUT - 1)) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
`ifdef ADC_AVG4_EN
          acc_d         = '0;
          avg_cnt_d     = '0;
`endif
        end
      end
      CAPTURE: begin
        state_d       = IDLE;
        err_timeout_d = 1'b0;
`ifdef ADC_AVG4_EN
        avg_cnt_d = avg_cnt_q + 2'd1;
        if (avg_cnt_q == 2'd3) begin
          sample_d       = acc_sum[ACC_W-1:2];
          sample_valid_d = 1'b1;
          if (sample_valid_q && !sample_ack) overrun_d = 1'b1;
          acc_d          = '0;
        end else begin
          acc_d = acc_sum;
        end
`else
        sample_d       = data_in;
        sample_valid_d = 1'b1;
        if (sample_valid_q && !sample_ack) overrun_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
    if (state_d == IDLE && state_q != IDLE) done_seen_d = 1'b0;
  end

  // Pin-facing controls are registered from the next state so they change cleanly with it.
  assign cs_n_d  = !cs_active(state_d);
  assign rx_en_d = cs_active(state_d);
  assign busy_d  = (state_d != IDLE);

  always_ff @(posedge clk_Nexys or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      period_q       <= '0;
      timer_q        <= '0;
      edge_cnt_q     <= '0;
      done_seen_q    <= 1'b0;
      cs_n_q         <= 1'b1;
      rx_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      timer_q        <= timer_d;
      edge_cnt_q     <= edge_cnt_d;
      done_seen_q    <= done_seen_d;
      cs_n_q         <= cs_n_d;
      rx_en_q        <= rx_en_d;
      busy_q         <= busy_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

`ifdef ADC_AVG4_EN
  always_ff @(posedge clk_Nexys or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`endif

  assign ADCcs_n      = cs_n_q;
  assign rx_en        = rx_en_q;
  assign busy         = busy_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign err_timeout  = err_timeout_q;

endmodule
